// File: rtl/regfile_param.sv
// Parametrised register file: N combinational read ports, one byte-enabled write port,
// optional bypass and hardwired R0, per-register pending scoreboard and a sequential clear sweep.
module regfile_rd_port #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 16,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter int BYPASS   = 1
) (
  input  logic [NUM_REGS-1:0][DATA_W-1:0] regs,
  input  logic [NUM_REGS-1:0]             pending,
  input  logic [ADDR_W-1:0]               rs,
  input  logic                            byp_en,
  input  logic [ADDR_W-1:0]               byp_addr,
  input  logic [DATA_W-1:0]               byp_data,
  input  logic                            byp_pend,
  output logic [DATA_W-1:0]               data,
  output logic                            pend
);
  always_comb begin
    data = regs[rs];
    pend = pending[rs];
    if (BYPASS != 0 && byp_en && rs == byp_addr) begin
      data = byp_data;
      pend = byp_pend;
    end
  end
endmodule

module regfile_param #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 16,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter int NUM_RD   = 3,
  parameter int BYPASS   = 1,
  parameter int ZERO_R0  = 0,
  parameter int TAP_IDX  = 6
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_enable,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [DATA_W/8-1:0]      wr_be,
  input  logic [NUM_RD*ADDR_W-1:0] rs,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_pending,
  input  logic                     rsv_en,
  input  logic [ADDR_W-1:0]        rsv_addr,
  input  logic                     clr_req,
  output logic                     clr_busy,
  output logic                     clr_done,
  output logic [DATA_W-1:0]        tap_data
);
  localparam int NB = DATA_W / 8;

  typedef enum logic {S_IDLE, S_CLEAR} state_t;

  state_t                         state_q, state_d;
  logic [ADDR_W-1:0]              cnt;
  logic [NUM_REGS-1:0][DATA_W-1:0] regs;
  logic [NUM_REGS-1:0]            pending;
  logic                           idle, wr_ok, rsv_ok, byp_pend;
  logic [DATA_W-1:0]              wr_merged;

  assign idle   = (state_q == S_IDLE);
  // R0 drops writes/reservations when hardwired, so it never leaves its reset value
  assign wr_ok  = wr_enable && idle && !(ZERO_R0 != 0 && wr_addr == '0);
  assign rsv_ok = rsv_en && idle && !(ZERO_R0 != 0 && rsv_addr == '0);
  assign byp_pend = rsv_ok && (rsv_addr == wr_addr);

  always_comb begin
    wr_merged = regs[wr_addr];
    for (int i = 0; i < NB; i++)
      if (wr_be[i]) wr_merged[i*8 +: 8] = wr_data[i*8 +: 8];
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (clr_req) state_d = S_CLEAR;
      S_CLEAR: if (cnt == ADDR_W'(NUM_REGS-1)) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign clr_busy = (state_q == S_CLEAR);
  assign clr_done = (state_q == S_CLEAR) && (cnt == ADDR_W'(NUM_REGS-1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      regs    <= '0;
      pending <= '0;
      state_q <= S_IDLE;
      cnt     <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_CLEAR) begin
        regs[cnt]    <= '0;
        pending[cnt] <= 1'b0;
        cnt          <= cnt + ADDR_W'(1);
      end else begin
        cnt <= '0;
        if (wr_ok) begin
          regs[wr_addr]    <= wr_merged;
          pending[wr_addr] <= 1'b0;
        end
        // reserve after write so a same-index reserve wins
        if (rsv_ok) pending[rsv_addr] <= 1'b1;
      end
    end
  end

  assign tap_data = regs[TAP_IDX];

  genvar k;
  generate
    for (k = 0; k < NUM_RD; k++) begin : g_rd
      regfile_rd_port #(
        .DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .BYPASS(BYPASS)
      ) u_rd (
        .regs     (regs),
        .pending  (pending),
        .rs       (rs[k*ADDR_W +: ADDR_W]),
        .byp_en   (wr_ok),
        .byp_addr (wr_addr),
        .byp_data (wr_merged),
        .byp_pend (byp_pend),
        .data     (rd_data[k*DATA_W +: DATA_W]),
        .pend     (rd_pending[k])
      );
    end
  endgenerate
endmodule

// File: tb/tb_regfile_param.sv
// Bench for regfile_param: default build checked against an array model, plus a
// wide 4-port build with hardwired R0 and no bypass checked by directed steps.
module tb_regfile_param;
  logic clk, rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // default instance: 16x32, 3 ports, bypass on, R0 normal, tap R6
  logic        wr_enable, rsv_en, clr_req, clr_busy, clr_done;
  logic [3:0]  wr_addr, rsv_addr, wr_be;
  logic [31:0] wr_data, tap_data;
  logic [11:0] rs;
  logic [95:0] rd_data;
  logic [2:0]  rd_pending;

  regfile_param dut_a (
    .clk(clk), .rst(rst), .wr_enable(wr_enable), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_be(wr_be), .rs(rs), .rd_data(rd_data), .rd_pending(rd_pending), .rsv_en(rsv_en),
    .rsv_addr(rsv_addr), .clr_req(clr_req), .clr_busy(clr_busy), .clr_done(clr_done),
    .tap_data(tap_data)
  );

  // wide instance: 32x64, 4 ports, no bypass, hardwired R0, tap R31
  logic         b_wr_enable, b_rsv_en, b_clr_req, b_clr_busy, b_clr_done;
  logic [4:0]   b_wr_addr, b_rsv_addr;
  logic [7:0]   b_wr_be;
  logic [63:0]  b_wr_data, b_tap;
  logic [19:0]  b_rs;
  logic [255:0] b_rd_data;
  logic [3:0]   b_rd_pending;

  regfile_param #(.DATA_W(64), .NUM_REGS(32), .NUM_RD(4), .BYPASS(0), .ZERO_R0(1), .TAP_IDX(31)) dut_b (
    .clk(clk), .rst(rst), .wr_enable(b_wr_enable), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
    .wr_be(b_wr_be), .rs(b_rs), .rd_data(b_rd_data), .rd_pending(b_rd_pending), .rsv_en(b_rsv_en),
    .rsv_addr(b_rsv_addr), .clr_req(b_clr_req), .clr_busy(b_clr_busy), .clr_done(b_clr_done),
    .tap_data(b_tap)
  );

  int checks = 0;
  int errors = 0;

  // reference model for the default instance
  logic [31:0] m [16];
  bit          mp [16];
  int          sw;  // -1 when idle, else index being cleared this cycle

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d, input logic [3:0] be);
    logic [31:0] r = o;
    for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = d[b*8 +: 8];
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin m[i] = '0; mp[i] = 1'b0; end
    sw = -1;
  endtask

  task automatic model_edge();
    if (sw >= 0) begin
      m[sw] = '0; mp[sw] = 1'b0; sw++;
      if (sw == 16) sw = -1;
    end else begin
      if (wr_enable) begin
        m[wr_addr] = merge(m[wr_addr], wr_data, wr_be);
        mp[wr_addr] = 1'b0;
      end
      if (rsv_en) mp[rsv_addr] = 1'b1;
      if (clr_req) sw = 0;
    end
  endtask

  // called just after a falling edge with inputs set; checks outputs, then advances one clock
  task automatic tick_a();
    logic [3:0]  idx;
    logic [31:0] ed;
    bit          ep;
    #1;
    for (int k = 0; k < 3; k++) begin
      idx = rs[k*4 +: 4];
      if (sw < 0 && wr_enable && idx == wr_addr) begin
        ed = merge(m[idx], wr_data, wr_be);
        ep = rsv_en && (rsv_addr == wr_addr);
      end else begin
        ed = m[idx];
        ep = mp[idx];
      end
      chk($sformatf("rd_data%0d", k), rd_data[k*32 +: 32], ed);
      chk($sformatf("rd_pending%0d", k), rd_pending[k], ep);
    end
    chk("clr_busy", clr_busy, sw >= 0);
    chk("clr_done", clr_done, sw == 15);
    chk("tap_data", tap_data, m[6]);
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle_a();
    wr_enable = 0; rsv_en = 0; clr_req = 0; wr_be = 4'h0;
  endtask

  initial begin
    int busy_cnt;
    rst = 0;
    idle_a(); wr_addr = 0; wr_data = 0; rsv_addr = 0; rs = 0;
    b_wr_enable = 0; b_rsv_en = 0; b_clr_req = 0; b_wr_addr = 0; b_rsv_addr = 0;
    b_wr_be = 0; b_wr_data = 0; b_rs = 0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_busy", clr_busy, 1'b0);
    chk("rst_done", clr_done, 1'b0);
    chk("rst_rd", rd_data, 96'h0);
    chk("rst_pend", rd_pending, 3'b000);
    rst = 1;
    @(negedge clk);

    // basic write and readback
    wr_enable = 1; wr_addr = 3; wr_data = 32'hDEADBEEF; wr_be = 4'hF;
    tick_a();
    idle_a(); rs = {4'd0, 4'd0, 4'd3};
    #1 chk("r3_val", rd_data[31:0], 32'hDEADBEEF);
    chk("r3_pend", rd_pending[0], 1'b0);
    tick_a();

    // asynchronous reset mid-run
    rst = 0;
    #1 chk("async_rst", rd_data[31:0], 32'h0);
    model_reset();
    #2 rst = 1;

    // byte-enabled write and same-cycle bypass
    wr_enable = 1; wr_addr = 5; wr_data = 32'h11223344; wr_be = 4'hF;
    tick_a();
    wr_data = 32'hAABBCCDD; wr_be = 4'b0101; rs = {4'd0, 4'd5, 4'd0};
    #1 chk("bypass_merge", rd_data[63:32], 32'h11BB33DD);
    tick_a();
    idle_a();
    #1 chk("r5_merge", rd_data[63:32], 32'h11BB33DD);
    tick_a();

    // reservations
    rsv_en = 1; rsv_addr = 7; rs = {4'd7, 4'd7, 4'd7};
    tick_a();
    idle_a();
    #1 chk("rsv_all_ports", rd_pending, 3'b111);
    tick_a();
    wr_enable = 1; wr_addr = 7; wr_data = 32'h1; wr_be = 4'h0;
    tick_a();
    idle_a();
    #1 chk("wr_clr_pend", rd_pending, 3'b000);
    tick_a();
    wr_enable = 1; wr_data = 32'h77; wr_be = 4'hF; rsv_en = 1; rsv_addr = 7;
    tick_a();
    idle_a();
    #1 chk("wr_rsv_data", rd_data[31:0], 32'h77);
    chk("wr_rsv_pend", rd_pending[0], 1'b1);
    tick_a();

    // clear sweep
    for (int i = 0; i < 16; i++) begin
      wr_enable = 1; wr_addr = 4'(i); wr_data = 32'(i + 1); wr_be = 4'hF;
      tick_a();
    end
    wr_addr = 4'd15; wr_data = 32'h55; clr_req = 1;
    tick_a();
    idle_a();
    busy_cnt = 0;
    for (int c = 1; c <= 16; c++) begin
      if (c == 5) begin wr_enable = 1; wr_addr = 2; wr_data = 32'hEE; wr_be = 4'hF; clr_req = 1; end
      else idle_a();
      rs = (c == 8) ? {4'd0, 4'd0, 4'd12} : {4'd2, 4'd15, 4'd6};
      #1 if (clr_busy) busy_cnt++;
      if (c == 8) chk("mid_sweep_r12", rd_data[31:0], 32'd13);
      if (c == 16) chk("done_last", clr_done, 1'b1);
      tick_a();
    end
    idle_a();
    chk("busy_cycles", busy_cnt, 16);
    for (int i = 0; i < 16; i += 3) begin
      rs = {4'(i + 2), 4'(i + 1), 4'(i)};
      tick_a();
    end

    // reset aborts a sweep
    clr_req = 1;
    tick_a();
    idle_a();
    repeat (3) tick_a();
    rst = 0;
    #1 chk("abort_busy", clr_busy, 1'b0);
    model_reset();
    #2 rst = 1;

    // randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      wr_enable = ($urandom_range(0, 1) == 1);
      wr_addr   = 4'($urandom);
      wr_data   = $urandom;
      wr_be     = 4'($urandom);
      rsv_en    = ($urandom_range(0, 3) == 0);
      rsv_addr  = ($urandom_range(0, 3) == 0) ? wr_addr : 4'($urandom);
      clr_req   = ($urandom_range(0, 39) == 0);
      rs        = 12'($urandom);
      tick_a();
    end
    idle_a();

    // wide instance: no bypass, tap, four ports on one register
    b_wr_enable = 1; b_wr_addr = 31; b_wr_data = 64'h0123456789ABCDEF; b_wr_be = 8'hFF;
    b_rs = {4{5'd31}};
    #1 chk("b_no_bypass", b_rd_data[63:0], 64'h0);
    @(posedge clk); @(negedge clk);
    b_wr_enable = 0;
    #1 chk("b_tap", b_tap, 64'h0123456789ABCDEF);
    for (int k = 0; k < 4; k++)
      chk($sformatf("b_rd%0d", k), b_rd_data[k*64 +: 64], 64'h0123456789ABCDEF);

    // hardwired R0
    b_wr_enable = 1; b_wr_addr = 0; b_wr_data = 64'h5; b_rsv_en = 1; b_rsv_addr = 0;
    b_rs = {5'd0, 5'd0, 5'd15, 5'd0};
    @(posedge clk); @(negedge clk);
    b_wr_enable = 0; b_rsv_en = 0;
    #1 chk("b_r0_data", b_rd_data[63:0], 64'h0);
    chk("b_r0_pend", b_rd_pending[0], 1'b0);
    b_wr_enable = 1; b_wr_addr = 15; b_wr_data = 64'h9; b_rsv_en = 1; b_rsv_addr = 20;
    @(posedge clk); @(negedge clk);
    b_wr_enable = 0; b_rsv_en = 0; b_rs = {5'd0, 5'd0, 5'd20, 5'd15};
    #1 chk("b_r15", b_rd_data[63:0], 64'h9);
    chk("b_r20_pend", b_rd_pending[1], 1'b1);
    chk("b_busy", b_clr_busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/regfile_param.md
Name: regfile_param

Overview:
- Parametrised successor to the processor's 16x32 three-read register file.
- Provides N combinational read ports, one byte-enabled write port, optional write-to-read bypass, and an optional hardwired-zero register.
- Keeps a per-register pending scoreboard for multi-cycle producers and a sequential clear engine.
- Exposes one tap register (e.g. audio sample or status flag) to the peripherals.

Parameters:
- DATA_W, 32, register width in bits; must be a multiple of 8.
- NUM_REGS, 16, register count; must be a power of 2 and at least 2.
- ADDR_W, $clog2(NUM_REGS), register index width.
- NUM_RD, 3, number of read ports.
- BYPASS, 1, 1 = a same-cycle write is visible on read ports; 0 = reads see registered contents only.
- ZERO_R0, 0, 1 = R0 reads as 0 and ignores writes and reservations.
- TAP_IDX, 6, index of the register driven on tap_data.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- wr_enable  in  1  write strobe.
- wr_addr  in  ADDR_W  write index.
- wr_data  in  DATA_W  write data.
- wr_be  in  DATA_W/8  byte enables; bit i gates byte i.
- rs  in  NUM_RD*ADDR_W  packed read indices; port k uses slice k.
- rd_data  out  NUM_RD*DATA_W  packed read data, combinational.
- rd_pending  out  NUM_RD  pending bit of each read port's register, combinational.
- rsv_en  in  1  reserve strobe; marks a register pending.
- rsv_addr  in  ADDR_W  register index to reserve.
- clr_req  in  1  start a sequential clear.
- clr_busy  out  1  clear sweep in progress.
- clr_done  out  1  one-cycle pulse on the last sweep cycle.
- tap_data  out  DATA_W  registered contents of R[TAP_IDX], no bypass.

Behaviour:
- Reset (rst=0, asynchronous): all registers = 0, all pending bits = 0, FSM = IDLE, sweep counter = 0, clr_busy = 0, clr_done = 0. Reset asserted mid-sweep aborts the sweep immediately.
- Write: at the edge where wr_enable=1 and FSM=IDLE, each byte i of R[wr_addr] with wr_be[i]=1 takes wr_data byte i; the other bytes hold. wr_be=0 writes nothing but still clears pending.
- Write clears pending[wr_addr]. This applies to every index, including R(NUM_REGS-1); there is no special-cased top register.
- Reserve: at the edge where rsv_en=1 and FSM=IDLE, pending[rsv_addr] is set.
- Write and reserve to the same index in one cycle: data is written and pending ends at 1 (reserve wins). Different indices: both take effect.
- ZERO_R0=1: writes and reservations to index 0 are dropped; R0 reads 0 with pending 0.
- Read, BYPASS=0: rd_data[k] = R[rs[k]]; rd_pending[k] = pending[rs[k]].
- Read, BYPASS=1: if wr_enable=1, FSM=IDLE and rs[k]==wr_addr, then:
  - rd_data[k] = byte-merge of R[rs[k]] and wr_data under wr_be;
  - rd_pending[k] = (rsv_en and rsv_addr==wr_addr).
  - Otherwise reads are as for BYPASS=0.
- Any number of read ports may address the same register.
- Clear FSM, IDLE state: clr_req=1 moves to CLEAR with counter=0. A write or reserve presented in that same cycle still executes.
- Clear FSM, CLEAR state: each cycle R[counter]=0, pending[counter]=0, counter+1.
  - When counter==NUM_REGS-1, clr_done=1 for that cycle and FSM returns to IDLE.
  - clr_busy=1 throughout CLEAR; the sweep lasts exactly NUM_REGS cycles.
- During CLEAR: wr_enable, rsv_en and clr_req are ignored (dropped, not queued). Reads return current contents, so some registers are cleared and some are not yet.
- The counter is ADDR_W wide and wraps to 0 on exit.
- No latency on reads. Write-to-readback latency is 1 edge, or 0 with BYPASS.

Test Plan:
- Reset, then write 0xDEADBEEF to R3 with wr_be=4'hF; next cycle rs0=3 -> rd_data0=0xDEADBEEF, pending=0. Assert rst=0 mid-run -> R3 reads 0 immediately.
- R5=0x11223344; write 0xAABBCCDD with wr_be=4'b0101 -> R5=0x11BB33DD. With BYPASS=1 and rs1=5 during the write cycle -> rd_data1=0x11BB33DD in that same cycle.
- Reserve R7 -> rd_pending=1 on all ports reading 7. Write R7 -> pending 0 next cycle. Write and reserve R7 in the same cycle -> data updated, pending=1.
- ZERO_R0=1: write 0x5 to R0 and reserve R0 -> R0 reads 0 with pending 0. Write 0x9 to R15 -> R15 reads 0x9.
- Fill R0..R15 with their index+1, pulse clr_req -> clr_busy high for 16 cycles, clr_done on the 16th, all registers read 0 afterwards. A write to R2 in cycle 5 of the sweep is dropped. At cycle 8 of the sweep, R12 still reads 13.
- NUM_RD=4, DATA_W=64, NUM_REGS=32, TAP_IDX=31: write R31=0x0123456789ABCDEF -> tap_data matches one cycle later; all 4 ports reading 31 return the value.
